// File: rtl/instr_fetch_unit_pkg.sv
// Shared MIPS32 definitions used by the fetch stage.
// Contents: opcode constants for the main decoder, the fetch FSM state
// encoding, and the default program-counter value loaded on reset.
package mips_pkg;

    // Primary opcode field values, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Fetch FSM: FETCH waits for the memory ack, ISSUE presents the word
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_ISSUE = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/ack bus.
//   imem_req   : fetch request, held until acked
//   imem_addr  : word-aligned fetch address, stable while imem_req=1
//   imem_ack   : one-cycle acknowledge, imem_rdata valid in the same cycle
//   imem_rdata : instruction word returned by memory
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Next-PC selection for the fetch stage (purely combinational).
//   pc_plus4  in  : PC+4 of the issuing instruction
//   instr_idx in  : instr[25:0], jump target index
//   sign_imm  in  : sign-extended branch immediate (word offset)
//   branch    in  : BEQ-class instruction
//   zero      in  : ALU equality result
//   jump      in  : J-class instruction
//   next_pc   out : jump target, taken branch target, or PC+4 (in that priority)
module next_pc_sel (
    input  logic        [31:0] pc_plus4,
    input  logic        [25:0] instr_idx,
    input  logic signed [31:0] sign_imm,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    output logic        [31:0] next_pc
);

    logic signed [31:0] br_offset;
    logic        [31:0] br_target;
    logic        [31:0] j_target;

    // Word offset to byte offset; the top two immediate bits fall off,
    // and the add wraps modulo 2^32.
    assign br_offset = sign_imm <<< 2;
    assign br_target = pc_plus4 + $unsigned(br_offset);
    assign j_target  = {pc_plus4[31:28], instr_idx, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = j_target;
        end else if (branch && zero) begin
            next_pc = br_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS32 instruction fetch stage.
// Holds the PC, fetches one word at a time over the imem req/ack bus, and
// presents it to decode/execute until it issues; the decoder's branch/jump
// and the ALU zero flag come back to pick the next PC.
//   clk, reset  : clock, synchronous active-high reset
//   imem        : instruction-memory bus (master side)
//   stall       : downstream not ready, hold the presented instruction
//   branch/zero/jump/sign_imm : next-PC controls, sampled when issuing
//   instr, opcode, instr_valid, pc_plus4 : presented instruction
//   retired_cnt : number of issued instructions (wraps)
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  imem,
    input  logic                stall,
    input  logic                branch,
    input  logic                zero,
    input  logic                jump,
    input  logic signed [31:0]  sign_imm,
    output logic        [31:0]  instr,
    output logic        [5:0]   opcode,
    output logic                instr_valid,
    output logic        [31:0]  pc_plus4,
    output logic        [31:0]  retired_cnt
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  retired_q, retired_d;
    logic [31:0]  next_pc;

    next_pc_sel u_next_pc_sel (
        .pc_plus4  (pc_plus4),
        .instr_idx (instr_q[25:0]),
        .sign_imm  (sign_imm),
        .branch    (branch),
        .zero      (zero),
        .jump      (jump),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // Ack outside FETCH carries nothing we asked for and is dropped; the
    // branch controls only matter on the cycle the instruction leaves.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset gates the request and valid in the reset cycle itself, so an
    // in-flight request is withdrawn immediately.
    assign imem.imem_req  = (state_q == ST_FETCH) && !reset;
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == ST_ISSUE) && !reset;
    assign instr          = instr_q;
    assign opcode         = instr_q[31:26];
    assign pc_plus4       = pc_q + 32'd4;
    assign retired_cnt    = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, branch, zero, jump;
    logic [31:0] sign_imm;
    logic [31:0] instr, pc_plus4, retired_cnt;
    logic [5:0]  opcode;
    logic        instr_valid;

    instr_fetch_unit_if imem ();

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem.master),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .sign_imm    (sign_imm),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc_plus4    (pc_plus4),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ADDI_W = 32'h2008_0005;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: PC, whether an instruction is held, held word, count
    logic [31:0] m_pc, m_instr, m_cnt;
    bit          m_have;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("req",     {31'd0, imem.imem_req}, {31'd0, (!m_have && !reset)});
        chk("addr",    imem.imem_addr, m_pc);
        chk("valid",   {31'd0, instr_valid}, {31'd0, (m_have && !reset)});
        chk("instr",   instr, m_instr);
        chk("opcode",  {26'd0, opcode}, {26'd0, m_instr[31:26]});
        chk("pc4",     pc_plus4, m_pc + 32'd4);
        chk("retired", retired_cnt, m_cnt);
    endtask

    task automatic model_step();
        logic [31:0] seq;
        if (reset) begin
            m_pc = 32'h0; m_have = 0; m_instr = 32'h0; m_cnt = 32'h0;
        end else if (!m_have) begin
            if (imem.imem_ack) begin
                m_instr = imem.imem_rdata;
                m_have  = 1;
            end
        end else if (!stall) begin
            seq = m_pc + 32'd4;
            if (jump)
                m_pc = (seq & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 32'd4);
            else if (branch && zero)
                m_pc = seq + sign_imm * 32'd4;
            else
                m_pc = seq;
            m_cnt  = m_cnt + 32'd1;
            m_have = 0;
        end
    endtask

    // Called just after a negedge: drive, clock, update model, check at negedge
    task automatic cycle(input logic rst_i, input logic ack_i, input logic [31:0] rdata_i,
                         input logic stall_i, input logic br_i, input logic z_i,
                         input logic j_i, input logic [31:0] simm_i);
        reset           = rst_i;
        imem.imem_ack   = ack_i;
        imem.imem_rdata = rdata_i;
        stall           = stall_i;
        branch          = br_i;
        zero            = z_i;
        jump            = j_i;
        sign_imm        = simm_i;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        cycle(1, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] w);
        cycle(0, 1, w, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic issue(input logic br_i, input logic z_i, input logic j_i, input logic [31:0] simm_i);
        cycle(0, 0, 32'h0, 0, br_i, z_i, j_i, simm_i);
    endtask

    task automatic advance(input int n);
        for (int k = 0; k < n; k++) begin
            fetch(ADDI_W);
            issue(0, 0, 0, 32'h0);
        end
    endtask

    logic [31:0] sv_instr, sv_pc4, sv_cnt;

    initial begin
        reset = 1'b1; imem.imem_ack = 1'b0; imem.imem_rdata = 32'h0;
        stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; sign_imm = 32'h0;
        @(negedge clk);

        // Reset state
        do_reset();
        chk("rst_req",   {31'd0, imem.imem_req}, 32'd0);
        chk("rst_addr",  imem.imem_addr, 32'h0);
        chk("rst_pc4",   pc_plus4, 32'h4);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_cnt",   retired_cnt, 32'd0);

        // Zero-wait stream of ADDI
        fetch(ADDI_W);
        chk("s_valid", {31'd0, instr_valid}, 32'd1);
        chk("s_instr", instr, 32'h2008_0005);
        chk("s_op",    {26'd0, opcode}, 32'h08);
        issue(0, 0, 0, 32'h0);
        chk("s_addr1", imem.imem_addr, 32'h4);
        chk("s_req1",  {31'd0, imem.imem_req}, 32'd1);
        fetch(ADDI_W);
        issue(0, 0, 0, 32'h0);
        chk("s_addr2", imem.imem_addr, 32'h8);
        fetch(ADDI_W);
        issue(0, 0, 0, 32'h0);
        chk("s_cnt", retired_cnt, 32'd3);

        // Ack withheld in FETCH
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 32'hDEAD_BEEF, 0, 1, 1, 1, 32'h7);
            chk("w_req",   {31'd0, imem.imem_req}, 32'd1);
            chk("w_addr",  imem.imem_addr, 32'h0);
            chk("w_valid", {31'd0, instr_valid}, 32'd0);
        end

        // BEQ taken / not taken from PC=0x10
        do_reset();
        advance(4);
        chk("b_pc", imem.imem_addr, 32'h10);
        fetch(32'h1000_FFFE);
        issue(1, 1, 0, 32'hFFFF_FFFE);
        chk("beq_taken", imem.imem_addr, 32'h0C);
        do_reset();
        advance(4);
        fetch(32'h1000_FFFE);
        issue(1, 0, 0, 32'hFFFF_FFFE);
        chk("beq_not", imem.imem_addr, 32'h14);

        // Jump beats branch at PC=0x4000_0000 (reached by a branch from 0)
        do_reset();
        fetch(32'h1000_0000);
        issue(1, 1, 0, 32'h0FFF_FFFF);
        chk("j_pc", imem.imem_addr, 32'h4000_0000);
        fetch(32'h0800_0010);
        issue(1, 1, 1, 32'h0001_2345);
        chk("j_win", imem.imem_addr, 32'h4000_0040);

        // Stall in ISSUE
        do_reset();
        advance(2);
        fetch(32'h0123_4567);
        sv_instr = instr; sv_pc4 = pc_plus4; sv_cnt = retired_cnt;
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 32'hFFFF_FFFF, 1, 1, 1, 1, 32'h100);
            chk("st_instr", instr, sv_instr);
            chk("st_pc4",   pc_plus4, sv_pc4);
            chk("st_cnt",   retired_cnt, sv_cnt);
            chk("st_req",   {31'd0, imem.imem_req}, 32'd0);
            chk("st_valid", {31'd0, instr_valid}, 32'd1);
        end
        issue(0, 0, 0, 32'h0);
        chk("st_rel", imem.imem_addr, 32'hC);
        chk("st_rcnt", retired_cnt, 32'd3);

        // Reset during a request at 0x20 with a simultaneous ack
        do_reset();
        advance(8);
        chk("r_pc", imem.imem_addr, 32'h20);
        cycle(1, 1, 32'hABCD_0123, 0, 0, 0, 0, 32'h0);
        chk("r_req",   {31'd0, imem.imem_req}, 32'd0);
        chk("r_instr", instr, 32'h0);
        chk("r_cnt",   retired_cnt, 32'd0);
        issue(0, 0, 0, 32'h0);
        chk("r_next",  imem.imem_addr, 32'h0);
        chk("r_req2",  {31'd0, imem.imem_req}, 32'd1);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom,
                  ($urandom_range(0, 9) < 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the MIPS32 core: holds the program counter, requests instructions from instruction memory over a req/ack handshake, and presents one instruction at a time to decode and execute. The opcode field drives the main decoder. The decoder's `branch`/`jump` outputs and the ALU `zero` flag return here to select the next PC. It also keeps a retired-instruction counter for debug.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 00.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: instruction-memory request, held until ack.
- `imem_addr` out 32: word-aligned fetch address (= PC), stable while `imem_req`=1.
- `imem_ack` in 1: one-cycle pulse; `imem_rdata` valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `stall` in 1: downstream not ready; holds the presented instruction.
- `branch` in 1: from main decoder, BEQ class.
- `zero` in 1: ALU equality result.
- `jump` in 1: from main decoder, J class.
- `sign_imm` in 32: sign-extended instr[15:0] from datapath.
- `instr` out 32: latched instruction.
- `opcode` out 6: instr[31:26], to main decoder.
- `instr_valid` out 1: `instr` is live for execute this cycle.
- `pc_plus4` out 32: PC+4 of the presented instruction.
- `retired_cnt` out 32: count of issued instructions.

## Operation
- Two-state FSM: FETCH, ISSUE.
- FETCH:
  - `imem_req`=1, `imem_addr`=PC.
  - On `imem_ack`: latch `imem_rdata` into `instr` and go to ISSUE.
  - Otherwise stay in FETCH, request and address held.
- ISSUE:
  - `instr_valid`=1.
  - If `stall`=1: stay; `instr`, PC and outputs frozen.
  - If `stall`=0: PC <= next_pc, `retired_cnt` +1, go to FETCH.
- next_pc priority:
  - `jump`=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else `branch`&`zero`: pc_plus4 + (sign_imm << 2).
  - else pc_plus4.
- Arithmetic:
  - All adds are modulo 2^32; wrap past 32'hFFFF_FFFC is silent.
  - sign_imm<<2 drops the top two bits.
- `branch`/`jump`/`zero`/`sign_imm` are sampled only in ISSUE with `stall`=0; ignored in all other cycles.
- `imem_ack` in ISSUE, or in the reset cycle, is ignored. No data is captured.
- `retired_cnt` wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values:
  - PC=RESET_PC, state=FETCH, `instr`=0, `instr_valid`=0, `retired_cnt`=0.
  - `imem_req`=0 during the reset cycle.
  - `imem_addr`=RESET_PC, `pc_plus4`=RESET_PC+4, `opcode`=0.
- First cycle after reset deasserts: `imem_req`=1.
- Ack in cycle N -> `instr_valid`=1 in cycle N+1.
- ISSUE without stall in cycle M -> `imem_req`=1 with the new PC in cycle M+1.
- Throughput: best case 2 cycles per instruction (zero-wait memory acks in the first FETCH cycle).
- `imem_req` never deasserts before its ack, except on reset.
- Reset mid-request or mid-issue aborts the operation; the next request is to RESET_PC.
- A late ack of the aborted request arriving in the reset cycle is dropped.
- `opcode` and `pc_plus4` are combinational from the `instr`/PC registers.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010);
  - FSM state encoding;
  - default reset PC constant.
- Sub-module `next_pc_sel` (combinational): inputs pc_plus4, instr[25:0], sign_imm, branch, zero, jump; output next_pc.
- FSM, PC, instr and counter registers live in the top.

## Test plan
- Reset, then ack every first request cycle with rdata 0x20080005 (ADDI) ->
  - `imem_addr` sequence 0x0, 0x4, 0x8;
  - `instr_valid` pulses every 2nd cycle;
  - `retired_cnt` reaches 3.
- Hold `imem_ack` low for 4 cycles in FETCH -> `imem_req`=1 and `imem_addr`=0x0 stable throughout; `instr_valid` stays 0.
- PC=0x10, BEQ with `branch`=1, `zero`=1, `sign_imm`=0xFFFF_FFFE -> next `imem_addr`=0x0C. Same with `zero`=0 -> 0x14.
- PC=0x4000_0000, instr=0x08000010 with `jump`=1 and `branch`=1, `zero`=1 simultaneously -> next `imem_addr`=0x4000_0040 (jump wins).
- `stall`=1 for 3 ISSUE cycles -> `instr`, `pc_plus4` and `retired_cnt` unchanged; no `imem_req`. Release -> fetch at PC+4.
- Assert `reset` while `imem_req`=1 at 0x20, with `imem_ack`=1 in the same cycle -> ack ignored; next request at RESET_PC; `retired_cnt`=0.
